// File: rtl/cr_huf_comp_pkg.sv
// Shared types for the Huffman compressor symbol-table read path.
// Holds the read-engine state encoding, the default-width layout of a
// symbol-table LUT entry and a small entry-filtering helper.
package cr_huf_compPKG;

    // Read-engine states.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PT    = 3'd1,
        ST_RD    = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } e_sa_rd_state;

    // Default field widths of one symbol-table LUT word.
    localparam int unsigned DEF_LEN_W  = 4;
    localparam int unsigned DEF_CODE_W = 15;

    // One LUT word as stored in the symbol table: length above code.
    typedef struct packed {
        logic [DEF_LEN_W-1:0]  len;
        logic [DEF_CODE_W-1:0] code;
    } s_lut_entry;

    // True when a returned LUT word must not reach the output stream:
    // zero-length suppression is on, the length is zero, and the word is
    // not the final symbol (the final symbol always carries the last flag).
    function automatic logic drop_entry(input logic skip,
                                        input logic len_zero,
                                        input logic is_last);
        return skip & len_zero & ~is_last;
    endfunction

endpackage

// File: rtl/cr_huf_comp_sa_skid.sv
// Two-entry skid buffer with valid/ready on both sides.
// The output word is always the registered head entry, so it is stable
// while the consumer stalls; vacated slots are zeroed so idle outputs read 0.
module cr_huf_comp_sa_skid #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         srst,
    input  logic         in_vld,
    output logic         in_rdy,
    input  logic [W-1:0] in_data,
    output logic         out_vld,
    input  logic         out_rdy,
    output logic [W-1:0] out_data,
    output logic [1:0]   occ
);

    logic [W-1:0] ent0_r;
    logic [W-1:0] ent1_r;
    logic [1:0]   cnt_r;
    logic         push_s;
    logic         pop_s;

    assign out_vld  = (cnt_r != 2'd0);
    assign out_data = ent0_r;
    assign occ      = cnt_r;
    assign in_rdy   = (cnt_r != 2'd2) || out_rdy;
    assign push_s   = in_vld && in_rdy;
    assign pop_s    = out_vld && out_rdy;

    // Entry storage and occupancy; head entry (ent0) always feeds the output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent0_r <= {W{1'b0}};
            ent1_r <= {W{1'b0}};
            cnt_r  <= 2'd0;
        end else if (srst) begin
            ent0_r <= {W{1'b0}};
            ent1_r <= {W{1'b0}};
            cnt_r  <= 2'd0;
        end else begin
            case ({push_s, pop_s})
                2'b10: begin
                    if (cnt_r == 2'd0) begin
                        ent0_r <= in_data;
                    end else begin
                        ent1_r <= in_data;
                    end
                    cnt_r <= cnt_r + 2'd1;
                end
                2'b01: begin
                    ent0_r <= ent1_r;
                    ent1_r <= {W{1'b0}};
                    cnt_r  <= cnt_r - 2'd1;
                end
                2'b11: begin
                    if (cnt_r == 2'd1) begin
                        ent0_r <= in_data;
                    end else begin
                        ent0_r <= ent1_r;
                        ent1_r <= in_data;
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

endmodule

// File: rtl/cr_huf_comp_sa_st_rd.sv
// Symbol-table reader for the Huffman compressor.
// On a ready table it streams every LUT entry (optionally dropping
// zero-length ones) as {sym,len,code} with a last flag on the final symbol;
// on a pass-through block it emits a single marker entry instead.
// Reads are throttled so returned data always fits the 2-entry skid buffer.
module cr_huf_comp_sa_st_rd
    import cr_huf_compPKG::*;
#(
    parameter  int unsigned NUM_SYM = 286,
    parameter  int unsigned CODE_W  = 15,
    parameter  int unsigned LEN_W   = 4,
    localparam int unsigned AW      = $clog2(NUM_SYM)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    st_tbl_rdy,
    input  logic                    st_pass_thru,
    input  logic                    skip_zero,
    output logic                    lut_rd_en,
    output logic [AW-1:0]           lut_rd_addr,
    input  logic [LEN_W+CODE_W-1:0] lut_rd_data,
    output logic                    sa_out_vld,
    input  logic                    sa_out_rdy,
    output logic [AW-1:0]           sa_out_sym,
    output logic [LEN_W-1:0]        sa_out_len,
    output logic [CODE_W-1:0]       sa_out_code,
    output logic                    sa_out_last,
    output logic                    sa_out_pt,
    output logic                    sa_st_read_done
);

    // Buffered entry layout: {pt, last, sym, len, code}.
    localparam int unsigned   EW        = 2 + AW + LEN_W + CODE_W;
    localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_SYM - 1);

    e_sa_rd_state        state_r;
    e_sa_rd_state        state_nxt_s;
    logic [AW-1:0]       addr_r;
    logic                pend_r;
    logic [AW-1:0]       pend_addr_r;
    logic                skip_zero_r;
    logic                done_r;

    logic                rd_en_s;
    logic [2:0]          flight_sum_s;
    logic                pop_s;
    logic                hs_last_s;
    logic                lut_last_s;
    logic [LEN_W-1:0]    lut_len_s;
    logic [CODE_W-1:0]   lut_code_s;

    logic                skid_in_vld_s;
    logic                skid_in_rdy_s;
    logic [EW-1:0]       skid_in_data_s;
    logic                skid_out_vld_s;
    logic [EW-1:0]       skid_out_data_s;
    logic [1:0]          skid_occ_s;
    logic                skid_flush_s;

    assign lut_len_s  = lut_rd_data[LEN_W+CODE_W-1:CODE_W];
    assign lut_code_s = lut_rd_data[CODE_W-1:0];
    assign lut_last_s = (pend_addr_r == LAST_ADDR);

    assign sa_out_vld      = skid_out_vld_s;
    assign sa_out_pt       = skid_out_data_s[EW-1];
    assign sa_out_last     = skid_out_data_s[EW-2];
    assign sa_out_sym      = skid_out_data_s[EW-3 -: AW];
    assign sa_out_len      = skid_out_data_s[LEN_W+CODE_W-1:CODE_W];
    assign sa_out_code     = skid_out_data_s[CODE_W-1:0];
    assign sa_st_read_done = done_r;

    assign pop_s     = skid_out_vld_s && sa_out_rdy;
    assign hs_last_s = pop_s && sa_out_last;

    // The read strobe must see this cycle's pop to sustain one entry per
    // cycle with only two buffer slots, so it is decoded from registered
    // state plus the downstream ready rather than registered itself.
    assign lut_rd_en   = rd_en_s;
    assign lut_rd_addr = addr_r;

    // The buffer is empty by the time a job completes; clearing it there
    // guarantees every job starts from a clean buffer.
    assign skid_flush_s = (state_r == ST_DONE);

    // Read throttle: buffered entries (after this cycle's pop) plus the read
    // whose data returns this cycle must leave room for one more word.
    always_comb begin
        flight_sum_s = {1'b0, skid_occ_s} - {2'b00, pop_s} + {2'b00, pend_r};
        if ((state_r == ST_RD) && skid_in_rdy_s && (flight_sum_s < 3'd2)) begin
            rd_en_s = 1'b1;
        end else begin
            rd_en_s = 1'b0;
        end
    end

    // Buffer write side: pass-through marker at job start, else LUT returns
    // tagged with their address, minus suppressed zero-length entries.
    always_comb begin
        skid_in_vld_s  = 1'b0;
        skid_in_data_s = {EW{1'b0}};
        if ((state_r == ST_IDLE) && st_pass_thru && !st_tbl_rdy) begin
            skid_in_vld_s  = 1'b1;
            skid_in_data_s = {1'b1, 1'b1, {(EW-2){1'b0}}};
        end else if (pend_r &&
                     !drop_entry(skip_zero_r, (lut_len_s == {LEN_W{1'b0}}), lut_last_s)) begin
            skid_in_vld_s  = 1'b1;
            skid_in_data_s = {1'b0, lut_last_s, pend_addr_r, lut_len_s, lut_code_s};
        end else begin
            skid_in_vld_s  = 1'b0;
            skid_in_data_s = {EW{1'b0}};
        end
    end

    // Next-state decode; input levels only matter in IDLE and DONE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (st_tbl_rdy) begin
                    state_nxt_s = ST_RD;
                end else if (st_pass_thru) begin
                    state_nxt_s = ST_PT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_PT: begin
                if (hs_last_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_PT;
                end
            end
            ST_RD: begin
                if (rd_en_s && (addr_r == LAST_ADDR)) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_RD;
                end
            end
            ST_DRAIN: begin
                if (hs_last_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_DONE: begin
                if (!st_tbl_rdy && !st_pass_thru) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Address counter, in-flight tag, job options and the done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_r      <= {AW{1'b0}};
            pend_r      <= 1'b0;
            pend_addr_r <= {AW{1'b0}};
            skip_zero_r <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            pend_r <= rd_en_s;
            done_r <= (state_nxt_s == ST_DONE) && (state_r != ST_DONE);
            if (rd_en_s) begin
                pend_addr_r <= addr_r;
            end
            if (state_r == ST_IDLE) begin
                addr_r <= {AW{1'b0}};
                if (st_tbl_rdy) begin
                    skip_zero_r <= skip_zero;
                end
            end else if (rd_en_s && (addr_r != LAST_ADDR)) begin
                addr_r <= addr_r + AW'(1);
            end
        end
    end

    cr_huf_comp_sa_skid #(
        .W (EW)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .srst     (skid_flush_s),
        .in_vld   (skid_in_vld_s),
        .in_rdy   (skid_in_rdy_s),
        .in_data  (skid_in_data_s),
        .out_vld  (skid_out_vld_s),
        .out_rdy  (sa_out_rdy),
        .out_data (skid_out_data_s),
        .occ      (skid_occ_s)
    );

endmodule
